// File: rtl/sha256_pad_wsched_if.sv
// Handshake and bus bundle between the SHA-256 front end and its host,
// message SRAM and compression stage.
interface sha256_pad_wsched_if #(
   parameter int MAX_MESSAGE_LENGTH = 55,
   parameter int SYMBOL_WIDTH       = 8
);
   localparam int AW = $clog2(MAX_MESSAGE_LENGTH);

   logic                    main_go_sig;
   logic [AW-1:0]           msg_len;
   logic [SYMBOL_WIDTH-1:0] msg_mem_data;
   logic                    w_reg_read;
   logic [5:0]              w_reg_addr;
   logic                    regop_msg_mem_en;
   logic [AW-1:0]           regop_msg_mem_addr;
   logic                    regop_w_reg_rdy;
   logic [31:0]             regop_w_reg_data;

   modport master (
      output main_go_sig, msg_len, msg_mem_data, w_reg_read, w_reg_addr,
      input  regop_msg_mem_en, regop_msg_mem_addr, regop_w_reg_rdy, regop_w_reg_data
   );

   modport slave (
      input  main_go_sig, msg_len, msg_mem_data, w_reg_read, w_reg_addr,
      output regop_msg_mem_en, regop_msg_mem_addr, regop_w_reg_rdy, regop_w_reg_data
   );
endinterface

// File: rtl/sha256_pad_wsched.sv
// SHA-256 front end: fetches a 0..55 byte message, pads it into one 512-bit
// block and expands it into the 64-word schedule held in a readable register file.
module sha256_pad_wsched #(
   parameter int MAX_MESSAGE_LENGTH = 55,
   parameter int SYMBOL_WIDTH       = 8
) (
   input  logic               clock,
   input  logic               reset,
   sha256_pad_wsched_if.slave bus
);
   localparam int AW = $clog2(MAX_MESSAGE_LENGTH);

   typedef enum logic [1:0] {P_IDLE, P_READ, P_DRAIN, P_PAD} pad_state_t;
   typedef enum logic [1:0] {W_IDLE, W_EXPAND, W_READY} w_state_t;

   pad_state_t pad_st, pad_nxt;
   w_state_t   w_st, w_nxt;

   logic [AW-1:0]     len_q, cnt, mem_addr, addr_d;
   logic              mem_en, rd_vld, pad_rdy, rdy;
   logic [63:0][7:0]  pad_q;
   logic [511:0]      pad_flat;
   logic [63:0][31:0] w_q;
   logic [5:0]        step;
   logic [31:0]       rd_data, w_new;
   logic              go_ok, start, issue, do_pad, load, expand;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // A new run is only accepted once both engines are quiet and any previous
   // schedule has been published, so a held go still yields one rdy cycle per run.
   assign go_ok = bus.main_go_sig && (pad_st == P_IDLE) && !pad_rdy &&
                  ((w_st == W_IDLE) || ((w_st == W_READY) && rdy));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pad_st <= P_IDLE;
      else       pad_st <= pad_nxt;
   end

   always_comb begin
      pad_nxt = pad_st;
      start   = 1'b0;
      issue   = 1'b0;
      do_pad  = 1'b0;
      case (pad_st)
         P_IDLE: begin
            if (go_ok) begin
               start   = 1'b1;
               pad_nxt = (bus.msg_len == '0) ? P_PAD : P_READ;
            end
         end
         P_READ: begin
            issue = 1'b1;
            if (cnt == len_q - AW'(1)) pad_nxt = P_DRAIN;
         end
         P_DRAIN: begin
            if (!mem_en) pad_nxt = P_PAD;
         end
         P_PAD: begin
            do_pad  = 1'b1;
            pad_nxt = P_IDLE;
         end
         default: pad_nxt = P_IDLE;
      endcase
   end

   // SRAM returns data one edge after en/addr; rd_vld/addr_d track that lag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len_q    <= '0;
         cnt      <= '0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         rd_vld   <= 1'b0;
         addr_d   <= '0;
         pad_rdy  <= 1'b0;
         pad_q    <= '0;
      end else begin
         mem_en  <= issue;
         rd_vld  <= mem_en;
         addr_d  <= mem_addr;
         pad_rdy <= do_pad;
         if (start) begin
            len_q <= bus.msg_len;
            cnt   <= '0;
            pad_q <= '0;
         end
         if (issue) begin
            mem_addr <= cnt;
            cnt      <= cnt + AW'(1);
         end
         if (rd_vld) pad_q[6'd63 - 6'(addr_d)] <= 8'(bus.msg_mem_data);
         if (do_pad) begin
            pad_q[6'd63 - 6'(len_q)] <= 8'h80;
            pad_q[7:0]               <= 64'(len_q) << 3;
         end
      end
   end

   assign pad_flat = pad_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) w_st <= W_IDLE;
      else       w_st <= w_nxt;
   end

   always_comb begin
      w_nxt  = w_st;
      load   = 1'b0;
      expand = 1'b0;
      case (w_st)
         W_IDLE: begin
            if (pad_rdy) begin
               load  = 1'b1;
               w_nxt = W_EXPAND;
            end
         end
         W_EXPAND: begin
            expand = 1'b1;
            if (step == 6'd63) w_nxt = W_READY;
         end
         W_READY: begin
            if (go_ok) w_nxt = W_IDLE;
         end
         default: w_nxt = W_IDLE;
      endcase
   end

   assign w_new = sig1(w_q[step - 6'd2]) + w_q[step - 6'd7] +
                  sig0(w_q[step - 6'd15]) + w_q[step - 6'd16];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_q     <= '0;
         step    <= '0;
         rdy     <= 1'b0;
         rd_data <= '0;
      end else begin
         if (load) begin
            for (int j = 0; j < 16; j++) w_q[j] <= pad_flat[511-32*j -: 32];
            step <= 6'd16;
         end
         if (expand) begin
            w_q[step] <= w_new;
            step      <= step + 6'd1;
         end
         if (go_ok)                 rdy <= 1'b0;
         else if (w_st == W_READY)  rdy <= 1'b1;
         if (bus.w_reg_read) rd_data <= w_q[bus.w_reg_addr];
      end
   end

   assign bus.regop_msg_mem_en   = mem_en;
   assign bus.regop_msg_mem_addr = mem_addr;
   assign bus.regop_w_reg_rdy    = rdy;
   assign bus.regop_w_reg_data   = rd_data;
endmodule

// File: tb/tb_sha256_pad_wsched.sv
// Directed bench for sha256_pad_wsched: padding, schedule values, timing,
// go filtering and asynchronous reset.
module tb_sha256_pad_wsched;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [7:0]  mem   [0:63];
   logic [31:0] exp_w [0:63];

   sha256_pad_wsched_if #(.MAX_MESSAGE_LENGTH(55), .SYMBOL_WIDTH(8)) bus ();

   sha256_pad_wsched #(.MAX_MESSAGE_LENGTH(55), .SYMBOL_WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // synchronous message SRAM
   always @(posedge clock)
      if (bus.regop_msg_mem_en) bus.msg_mem_data <= mem[bus.regop_msg_mem_addr];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_model(input int len);
      logic [7:0] blk [0:63];
      for (int i = 0; i < 64; i++) blk[i] = (i < len) ? mem[i] : 8'h00;
      blk[len] = 8'h80;
      for (int i = 0; i < 8; i++) blk[63-i] = 8'((len * 8) >> (8 * i));
      for (int j = 0; j < 16; j++)
         exp_w[j] = {blk[4*j], blk[4*j+1], blk[4*j+2], blk[4*j+3]};
      for (int t = 16; t < 64; t++)
         exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) +
                    exp_w[t-7] +
                    (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) +
                    exp_w[t-16];
   endtask

   // Pulses go (sampled at edge 0) and watches edges 1..200 for en and rdy.
   task automatic go_and_wait(input int len, input int extra_go, output int rdy_at,
                              output int en_cnt, output bit seq_ok);
      @(negedge clock);
      bus.msg_len     = 6'(len);
      bus.main_go_sig = 1'b1;
      @(posedge clock); #1;
      bus.main_go_sig = 1'b0;
      rdy_at = -1; en_cnt = 0; seq_ok = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         if (n == extra_go) begin bus.main_go_sig = 1'b1; bus.msg_len = 6'd3; end
         @(posedge clock); #1;
         if (n == extra_go) begin bus.main_go_sig = 1'b0; bus.msg_len = 6'(len); end
         if (bus.regop_msg_mem_en) begin
            en_cnt++;
            if (int'(bus.regop_msg_mem_addr) != n - 1) seq_ok = 1'b0;
         end
         if (bus.regop_w_reg_rdy) begin rdy_at = n; break; end
      end
   endtask

   task automatic read_w(input int idx, output logic [31:0] d);
      @(negedge clock);
      bus.w_reg_addr = 6'(idx);
      bus.w_reg_read = 1'b1;
      @(posedge clock); #1;
      d = bus.regop_w_reg_data;
      bus.w_reg_read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(posedge clock);
      #1;
      total++; if (bus.regop_msg_mem_en !== 1'b0) begin bad++; $display("FAIL rst_en got %b want 0", bus.regop_msg_mem_en); end
      total++; if (bus.regop_msg_mem_addr !== 6'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", bus.regop_msg_mem_addr); end
      total++; if (bus.regop_w_reg_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got %b want 0", bus.regop_w_reg_rdy); end
      total++; if (bus.regop_w_reg_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h want 0", bus.regop_w_reg_data); end
      @(negedge clock); reset = 1'b0;
      read_w(0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_w0 got %h want 0", d); end
      read_w(63, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_w63 got %h want 0", d); end
   endtask

   task automatic test_abc();
      int rdy_at, en_cnt; bit seq_ok; logic [31:0] d;
      go_and_wait(3, 0, rdy_at, en_cnt, seq_ok);
      total++; if (en_cnt !== 3) begin bad++; $display("FAIL abc_en_cnt got %0d want 3", en_cnt); end
      total++; if (seq_ok !== 1'b1) begin bad++; $display("FAIL abc_addr_seq got %b want 1", seq_ok); end
      total++; if (rdy_at !== 56) begin bad++; $display("FAIL abc_rdy_edge got %0d want 56", rdy_at); end
      read_w(0, d);
      total++; if (d !== 32'h61626380) begin bad++; $display("FAIL abc_w0 got %h want 61626380", d); end
      for (int k = 1; k <= 14; k++) begin
         read_w(k, d);
         total++; if (d !== 32'h0) begin bad++; $display("FAIL abc_w%0d got %h want 0", k, d); end
      end
      read_w(15, d);
      total++; if (d !== 32'h00000018) begin bad++; $display("FAIL abc_w15 got %h want 00000018", d); end
      read_w(16, d);
      total++; if (d !== 32'h61626380) begin bad++; $display("FAIL abc_w16 got %h want 61626380", d); end
      read_w(17, d);
      total++; if (d !== 32'h000F0000) begin bad++; $display("FAIL abc_w17 got %h want 000f0000", d); end
   endtask

   task automatic test_empty();
      int rdy_at, en_cnt; bit seq_ok; logic [31:0] d;
      go_and_wait(0, 0, rdy_at, en_cnt, seq_ok);
      total++; if (en_cnt !== 0) begin bad++; $display("FAIL empty_en_cnt got %0d want 0", en_cnt); end
      total++; if (rdy_at !== 51) begin bad++; $display("FAIL empty_rdy_edge got %0d want 51", rdy_at); end
      read_w(0, d);
      total++; if (d !== 32'h80000000) begin bad++; $display("FAIL empty_w0 got %h want 80000000", d); end
      read_w(15, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL empty_w15 got %h want 0", d); end
      read_w(16, d);
      total++; if (d !== 32'h80000000) begin bad++; $display("FAIL empty_w16 got %h want 80000000", d); end
      read_w(17, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL empty_w17 got %h want 0", d); end
      read_w(18, d);
      total++; if (d !== 32'h00205000) begin bad++; $display("FAIL empty_w18 got %h want 00205000", d); end
   endtask

   task automatic test_len7_sweep();
      int rdy_at, en_cnt; bit seq_ok; logic [31:0] d;
      go_and_wait(7, 0, rdy_at, en_cnt, seq_ok);
      build_model(7);
      total++; if (en_cnt !== 7) begin bad++; $display("FAIL l7_en_cnt got %0d want 7", en_cnt); end
      total++; if (seq_ok !== 1'b1) begin bad++; $display("FAIL l7_addr_seq got %b want 1", seq_ok); end
      total++; if (rdy_at !== 60) begin bad++; $display("FAIL l7_rdy_edge got %0d want 60", rdy_at); end
      read_w(0, d);
      total++; if (d !== 32'h61626364) begin bad++; $display("FAIL l7_w0 got %h want 61626364", d); end
      read_w(1, d);
      total++; if (d[7:0] !== 8'h80) begin bad++; $display("FAIL l7_w1_lsb got %h want 80", d[7:0]); end
      total++; if (d !== 32'h65666780) begin bad++; $display("FAIL l7_w1 got %h want 65666780", d); end
      read_w(15, d);
      total++; if (d !== 32'h00000038) begin bad++; $display("FAIL l7_w15 got %h want 00000038", d); end
      @(negedge clock);
      bus.w_reg_read = 1'b1;
      bus.w_reg_addr = 6'd0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clock); #1;
         total++; if (bus.regop_w_reg_data !== exp_w[k]) begin bad++; $display("FAIL sweep_w%0d got %h want %h", k, bus.regop_w_reg_data, exp_w[k]); end
         if (k < 63) bus.w_reg_addr = 6'(k + 1);
      end
      bus.w_reg_read = 1'b0;
      bus.w_reg_addr = 6'd5;
      @(posedge clock); #1;
      total++; if (bus.regop_w_reg_data !== exp_w[63]) begin bad++; $display("FAIL read_hold got %h want %h", bus.regop_w_reg_data, exp_w[63]); end
   endtask

   task automatic test_go_ignored();
      int rdy_at, en_cnt; bit seq_ok; logic [31:0] d;
      go_and_wait(7, 30, rdy_at, en_cnt, seq_ok);
      total++; if (rdy_at !== 60) begin bad++; $display("FAIL ign_rdy_edge got %0d want 60", rdy_at); end
      total++; if (en_cnt !== 7) begin bad++; $display("FAIL ign_en_cnt got %0d want 7", en_cnt); end
      read_w(1, d);
      total++; if (d !== exp_w[1]) begin bad++; $display("FAIL ign_w1 got %h want %h", d, exp_w[1]); end
      read_w(15, d);
      total++; if (d !== exp_w[15]) begin bad++; $display("FAIL ign_w15 got %h want %h", d, exp_w[15]); end
      read_w(63, d);
      total++; if (d !== exp_w[63]) begin bad++; $display("FAIL ign_w63 got %h want %h", d, exp_w[63]); end
   endtask

   task automatic test_go_held();
      int rise1, fall1, rise2; logic prev; logic [31:0] d;
      @(negedge clock);
      bus.msg_len     = 6'd3;
      bus.main_go_sig = 1'b1;
      @(posedge clock); #1;
      rise1 = -1; fall1 = -1; rise2 = -1; prev = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clock); #1;
         if (bus.regop_w_reg_rdy && !prev) begin
            if (rise1 < 0) rise1 = n;
            else begin rise2 = n; break; end
         end
         if (!bus.regop_w_reg_rdy && prev && fall1 < 0) fall1 = n;
         prev = bus.regop_w_reg_rdy;
      end
      bus.main_go_sig = 1'b0;
      total++; if (rise1 !== 56) begin bad++; $display("FAIL held_rise1 got %0d want 56", rise1); end
      total++; if (fall1 !== 57) begin bad++; $display("FAIL held_fall1 got %0d want 57", fall1); end
      total++; if (rise2 !== 113) begin bad++; $display("FAIL held_rise2 got %0d want 113", rise2); end
      @(posedge clock); #1;
      total++; if (bus.regop_w_reg_rdy !== 1'b1) begin bad++; $display("FAIL held_rdy_stays got %b want 1", bus.regop_w_reg_rdy); end
      read_w(0, d);
      total++; if (d !== 32'h61626380) begin bad++; $display("FAIL held_w0 got %h want 61626380", d); end
   endtask

   task automatic test_reset_mid_run();
      int rdy_at, en_cnt; bit seq_ok; logic [31:0] d;
      @(negedge clock);
      bus.msg_len     = 6'd3;
      bus.main_go_sig = 1'b1;
      @(posedge clock); #1;
      bus.main_go_sig = 1'b0;
      bus.w_reg_read  = 1'b1;
      bus.w_reg_addr  = 6'd0;
      repeat (20) @(posedge clock);
      #3;
      total++; if (bus.regop_w_reg_data !== 32'h61626380) begin bad++; $display("FAIL mid_pre_data got %h want 61626380", bus.regop_w_reg_data); end
      reset = 1'b1;
      #1;
      total++; if (bus.regop_w_reg_data !== 32'h0) begin bad++; $display("FAIL mid_rst_data got %h want 0", bus.regop_w_reg_data); end
      total++; if (bus.regop_msg_mem_addr !== 6'd0) begin bad++; $display("FAIL mid_rst_addr got %0d want 0", bus.regop_msg_mem_addr); end
      total++; if (bus.regop_msg_mem_en !== 1'b0) begin bad++; $display("FAIL mid_rst_en got %b want 0", bus.regop_msg_mem_en); end
      total++; if (bus.regop_w_reg_rdy !== 1'b0) begin bad++; $display("FAIL mid_rst_rdy got %b want 0", bus.regop_w_reg_rdy); end
      bus.w_reg_read = 1'b0;
      @(negedge clock); reset = 1'b0;
      read_w(20, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_w20_cleared got %h want 0", d); end
      go_and_wait(3, 0, rdy_at, en_cnt, seq_ok);
      total++; if (rdy_at !== 56) begin bad++; $display("FAIL mid_rerun_rdy got %0d want 56", rdy_at); end
      read_w(0, d);
      total++; if (d !== 32'h61626380) begin bad++; $display("FAIL mid_rerun_w0 got %h want 61626380", d); end
      read_w(15, d);
      total++; if (d !== 32'h00000018) begin bad++; $display("FAIL mid_rerun_w15 got %h want 00000018", d); end
      read_w(17, d);
      total++; if (d !== 32'h000F0000) begin bad++; $display("FAIL mid_rerun_w17 got %h want 000f0000", d); end
   endtask

   initial begin
      bus.main_go_sig = 1'b0;
      bus.msg_len     = 6'd0;
      bus.w_reg_read  = 1'b0;
      bus.w_reg_addr  = 6'd0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      for (int i = 0; i < 7; i++) mem[i] = 8'(8'h61 + i);
      test_reset();
      test_abc();
      test_empty();
      test_len7_sweep();
      test_go_ignored();
      test_go_held();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
